relu_arbiter: RTL and testbench

- Shares one instance of the team's 1-cycle registered ReLU unit among NUM_REQ feature producers (PE/layer outputs).
- Grants are round-robin and made per burst, so a granted requester keeps the unit until it sends its last element.
- The block drives the ReLU x/enable inputs and captures the ReLU result one cycle after each issue.
- Results return through a small output FIFO, tagged with requester id and last flag, behind a valid/ready handshake.

---
 rtl/relu_arb_pkg.sv | 40 ++++
 rtl/relu_arb_fifo.sv | 54 +++++
 rtl/relu_arbiter.sv | 167 ++++++++++++++++
 tb/tb_relu_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/relu_arb_pkg.sv
// Shared types and helpers for the ReLU arbiter: FSM encoding, result tag, round-robin pick.
package relu_arb_pkg;

    localparam int MAX_ID_W = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam logic [0:0] ST_IDLE  = IDLE;
    localparam logic [0:0] ST_BURST = BURST;

    typedef struct packed {
        logic [MAX_ID_W-1:0] id;
        logic                last;
    } res_tag_t;

    // First requester with valid set, searching from ptr+1 and wrapping modulo n.
    function automatic logic [MAX_ID_W-1:0] rr_pick(
        input logic [15:0]         valid,
        input logic [MAX_ID_W-1:0] ptr,
        input int                  n
    );
        logic [MAX_ID_W-1:0] pick;
        logic                found;
        int                  idx;
        pick  = ptr;
        found = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            idx = (int'(ptr) + k) % n;
            if ((k <= n) && !found && valid[4'(idx)]) begin
                pick  = MAX_ID_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/relu_arb_fifo.sv
// Small synchronous show-ahead FIFO for tagged ReLU results; push and pop may coincide even when full.
module relu_arb_fifo #(
    parameter int DW    = 19,
    parameter int DEPTH = 2,
    parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_din,
    input  logic          i_pop,
    output logic [DW-1:0] o_dout,
    output logic          o_valid,
    output logic [CW-1:0] o_count
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_pop = i_pop & (r_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= r_count + CW'(i_push) - CW'(w_pop);
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

endmodule

// File: rtl/relu_arbiter.sv
// Round-robin, burst-granular sharing of one registered ReLU unit among NUM_REQ producers.
// Optional statistics counters are enabled with `define RELU_ARB_STATS_EN.
module relu_arbiter
    import relu_arb_pkg::*;
#(
    parameter int featureWidth = 16,
    parameter int NUM_REQ      = 4,
    parameter int OUT_DEPTH    = 2,
    parameter int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*featureWidth-1:0] req_data,
    input  logic [NUM_REQ-1:0]              req_last,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [featureWidth-1:0]         relu_x,
    output logic                            relu_en,
    input  logic [featureWidth-1:0]         relu_out,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [featureWidth-1:0]         out_data,
    output logic [ID_W-1:0]                 out_id,
    output logic                            out_last,
    output logic                            busy
`ifdef RELU_ARB_STATS_EN
    ,
    input  logic                            stats_clr,
    output logic [31:0]                     neg_count,
    output logic [31:0]                     burst_count
`endif
);

    localparam int DW = featureWidth + ID_W + 1;
    localparam int CW = $clog2(OUT_DEPTH + 1);

    logic [0:0]              r_state;
    logic [ID_W-1:0]         r_grant;
    logic [ID_W-1:0]         r_rr_ptr;
    logic                    r_relu_en;
    logic [featureWidth-1:0] r_relu_x;
    res_tag_t                r_s1_tag;
    res_tag_t                r_s2_tag;
    logic                    r_inflight;

    logic                    w_pop;
    logic                    w_can_issue;
    logic                    w_accept;
    logic                    w_grant_valid;
    logic                    w_grant_last;
    logic [featureWidth-1:0] w_grant_data;
    logic [MAX_ID_W-1:0]     w_pick;
    logic [CW:0]             w_used;
    logic [CW-1:0]           w_fifo_count;
    logic                    w_fifo_valid;
    logic [DW-1:0]           w_fifo_dout;
    logic [DW-1:0]           w_fifo_din;
    logic                    w_unused;

    assign w_grant_valid = req_valid[r_grant];
    assign w_grant_last  = req_last[r_grant];
    assign w_grant_data  = req_data[int'(r_grant)*featureWidth +: featureWidth];
    assign w_pick        = rr_pick(16'(req_valid), 4'(r_rr_ptr), NUM_REQ);

    // Credits cover both pipeline stages (ReLU input and ReLU output) so the FIFO can never overflow.
    assign w_pop       = w_fifo_valid & out_ready;
    assign w_used      = (CW+1)'(w_fifo_count) + (CW+1)'(r_relu_en) + (CW+1)'(r_inflight)
                         - (CW+1)'(w_pop);
    assign w_can_issue = (w_used < (CW+1)'(OUT_DEPTH));
    assign w_accept    = (r_state == ST_BURST) & w_can_issue & w_grant_valid;

    always_comb begin
        req_ready = '0;
        if ((r_state == ST_BURST) && w_can_issue) begin
            req_ready[r_grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_rr_ptr   <= ID_W'(NUM_REQ - 1);
            r_relu_en  <= 1'b0;
            r_relu_x   <= '0;
            r_s1_tag   <= '0;
            r_s2_tag   <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_relu_en  <= w_accept;
            r_inflight <= r_relu_en;
            r_s2_tag   <= r_s1_tag;
            if (w_accept) begin
                r_relu_x      <= w_grant_data;
                r_s1_tag.id   <= MAX_ID_W'(r_grant);
                r_s1_tag.last <= w_grant_last;
            end
            case (r_state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        r_grant <= ID_W'(w_pick);
                        r_state <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (w_accept && w_grant_last) begin
                        r_rr_ptr <= r_grant;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign relu_en = r_relu_en;
    assign relu_x  = r_relu_x;

    // relu_out is only meaningful one cycle after relu_en, which is exactly when r_inflight is set.
    assign w_fifo_din = {relu_out, r_s2_tag.id[ID_W-1:0], r_s2_tag.last};

    relu_arb_fifo #(
        .DW    (DW),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_inflight),
        .i_din   (w_fifo_din),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_valid (w_fifo_valid),
        .o_count (w_fifo_count)
    );

    assign out_valid                      = w_fifo_valid;
    assign {out_data, out_id, out_last}   = w_fifo_dout;
    assign busy = (r_state == ST_BURST) | r_relu_en | r_inflight | w_fifo_valid;

    assign w_unused = (|(r_s2_tag.id >> ID_W)) | (|(w_pick >> ID_W));

`ifdef RELU_ARB_STATS_EN
    logic [31:0] r_neg_count;
    logic [31:0] r_burst_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_neg_count   <= '0;
            r_burst_count <= '0;
        end else if (stats_clr) begin
            r_neg_count   <= '0;
            r_burst_count <= '0;
        end else if (w_accept) begin
            if (w_grant_data[featureWidth-1] && (r_neg_count != '1)) begin
                r_neg_count <= r_neg_count + 32'd1;
            end
            if (w_grant_last && (r_burst_count != '1)) begin
                r_burst_count <= r_burst_count + 32'd1;
            end
        end
    end

    assign neg_count   = r_neg_count;
    assign burst_count = r_burst_count;
`endif

endmodule

// File: tb/tb_relu_arbiter.sv
// Directed bench for relu_arbiter with a behavioural ReLU and an ordered result scoreboard.
module tb_relu_arbiter;

    localparam int FW = 16;
    localparam int NR = 4;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req_valid;
    logic [NR*FW-1:0] req_data;
    logic [NR-1:0]    req_last;
    logic [NR-1:0]    req_ready;
    logic [FW-1:0]    relu_x;
    logic             relu_en;
    logic [FW-1:0]    relu_out;
    logic             out_valid;
    logic             out_ready;
    logic [FW-1:0]    out_data;
    logic [IW-1:0]    out_id;
    logic             out_last;
    logic             busy;
`ifdef RELU_ARB_STATS_EN
    logic             stats_clr;
    logic [31:0]      neg_count;
    logic [31:0]      burst_count;
`endif

    relu_arbiter #(.featureWidth(FW), .NUM_REQ(NR), .OUT_DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .relu_x    (relu_x),
        .relu_en   (relu_en),
        .relu_out  (relu_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_last  (out_last),
        .busy      (busy)
`ifdef RELU_ARB_STATS_EN
        ,
        .stats_clr   (stats_clr),
        .neg_count   (neg_count),
        .burst_count (burst_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [FW-1:0] relu16(input logic [FW-1:0] x);
        return x[FW-1] ? '0 : x;
    endfunction

    // Behavioural registered ReLU; holds its output when not enabled and is not reset.
    always @(posedge clk) begin
        if (relu_en) relu_out <= relu16(relu_x);
    end

    typedef struct packed {
        logic [FW-1:0] data;
        logic [IW-1:0] id;
        logic          last;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            acc_cnt = 0;
    int            first_acc = -1;
    int            first_ov = -1;

    logic          v   [NR];
    logic [FW-1:0] dat [NR];
    logic          lst [NR];
    logic [FW-1:0] bdata [NR][8];
    int            blen [NR];
    int            gap  [NR][8];

    always_comb begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        for (int i = 0; i < NR; i++) begin
            req_valid[i]         = v[i];
            req_data[i*FW +: FW] = dat[i];
            req_last[i]          = lst[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            chk("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    acc_cnt++;
                    if (first_acc < 0) first_acc = cyc;
                end
            end
            if (out_valid && first_ov < 0) first_ov = cyc;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 32'(out_data), 32'hDEAD_BEEF);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", 32'(out_data), 32'(e.data));
                    chk("out_id",   32'(out_id),   32'(e.id));
                    chk("out_last", 32'(out_last), 32'(e.last));
                end
            end
        end
    end

    task automatic expect_burst(input int id);
        for (int k = 0; k < blen[id]; k++) begin
            sb.push_back('{data: relu16(bdata[id][k]), id: IW'(id), last: (k == blen[id] - 1)});
        end
    endtask

    task automatic send_burst(input int id);
        int t;
        for (int k = 0; k < blen[id]; k++) begin
            if (gap[id][k] > 0) begin
                v[id] = 1'b0;
                repeat (gap[id][k]) @(posedge clk);
                #1;
            end
            v[id]   = 1'b1;
            dat[id] = bdata[id][k];
            lst[id] = (k == blen[id] - 1);
            t = 0;
            @(negedge clk);
            while (!req_ready[id] && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) chk("accept_timeout", 32'(id), 32'hFFFF);
            @(posedge clk);
            #1;
        end
        v[id]   = 1'b0;
        lst[id] = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        @(negedge clk);
        while ((sb.size() != 0 || busy) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
        chk("drain_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int base;
        int t;
        for (int i = 0; i < NR; i++) begin
            v[i] = 1'b0; dat[i] = '0; lst[i] = 1'b0; blen[i] = 0;
            for (int k = 0; k < 8; k++) begin
                bdata[i][k] = '0;
                gap[i][k]   = 0;
            end
        end
        out_ready = 1'b1;
`ifdef RELU_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_relu_en",   32'(relu_en),   32'd0);
        chk("rst_relu_x",    32'(relu_x),    32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_word",  {13'd0, out_data, out_id, out_last}, 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single requester, negative element clamped, 3-cycle latency.
        blen[0] = 3; bdata[0][0] = 16'd5; bdata[0][1] = 16'hFFFD; bdata[0][2] = 16'd7;
        expect_burst(0);
        send_burst(0);
        drain();
        chk("first_latency", 32'(first_ov - first_acc), 32'd3);

        // Two contenders: 1 then 3, and the next round wraps back to 1.
        blen[1] = 2; bdata[1][0] = 16'h0101; bdata[1][1] = 16'h0102;
        blen[3] = 2; bdata[3][0] = 16'h0301; bdata[3][1] = 16'h8302;
        expect_burst(1); expect_burst(3);
        fork
            send_burst(1);
            send_burst(3);
        join
        drain();
        bdata[1][0] = 16'h0111; bdata[1][1] = 16'hF112;
        bdata[3][0] = 16'h0311; bdata[3][1] = 16'h0312;
        expect_burst(1); expect_burst(3);
        fork
            send_burst(1);
            send_burst(3);
        join
        drain();

        // Backpressure: only OUT_DEPTH elements may be outstanding.
        out_ready = 1'b0;
        blen[0] = 4;
        bdata[0][0] = 16'h0A01; bdata[0][1] = 16'h0A02; bdata[0][2] = 16'hCA03; bdata[0][3] = 16'h0A04;
        expect_burst(0);
        base = acc_cnt;
        fork
            send_burst(0);
            begin
                repeat (8) @(negedge clk);
                chk("bp_accepted",  32'(acc_cnt - base), 32'd2);
                chk("bp_req_ready", 32'(req_ready),      32'd0);
                chk("bp_out_valid", 32'(out_valid),      32'd1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Granted requester pauses; a waiting requester must not slip in.
        blen[2] = 4; gap[2][2] = 2;
        bdata[2][0] = 16'h0201; bdata[2][1] = 16'h0202; bdata[2][2] = 16'h0203; bdata[2][3] = 16'h0204;
        blen[0] = 2; bdata[0][0] = 16'h0001; bdata[0][1] = 16'h0002;
        expect_burst(2); expect_burst(0);
        fork
            send_burst(2);
            begin
                @(posedge clk);
                #1;
                send_burst(0);
            end
            begin
                repeat (4) @(negedge clk);
                chk("gap_req2_valid", 32'(req_valid[2]), 32'd0);
                chk("gap_req0_valid", 32'(req_valid[0]), 32'd1);
                chk("gap_req0_ready", 32'(req_ready[0]), 32'd0);
            end
        join
        drain();
        gap[2][2] = 0;

        // Reset with one result queued and one still inside the ReLU.
        out_ready = 1'b0;
        base = acc_cnt;
        v[1] = 1'b1; dat[1] = 16'h0555; lst[1] = 1'b0;
        t = 0;
        @(negedge clk);
        while ((acc_cnt - base) < 2 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("rstmid_two_accepts", 32'(acc_cnt - base), 32'd2);
        @(posedge clk);
        #1;
        v[1] = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rstmid_pre_out_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_out_valid", 32'(out_valid), 32'd0);
        chk("rstmid_req_ready", 32'(req_ready), 32'd0);
        chk("rstmid_busy",      32'(busy),      32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rstmid_no_capture", 32'(out_valid), 32'd0);
            chk("rstmid_idle_busy",  32'(busy),      32'd0);
        end
        @(posedge clk);
        #1;

`ifdef RELU_ARB_STATS_EN
        blen[0] = 3; bdata[0][0] = 16'hFFFF; bdata[0][1] = 16'd4; bdata[0][2] = 16'hFFF8;
        expect_burst(0);
        send_burst(0);
        drain();
        chk("stats_neg",   neg_count,   32'd2);
        chk("stats_burst", burst_count, 32'd1);
        stats_clr = 1'b1;
        @(posedge clk);
        #1;
        stats_clr = 1'b0;
        @(negedge clk);
        chk("stats_neg_clr",   neg_count,   32'd0);
        chk("stats_burst_clr", burst_count, 32'd0);
`endif

        chk("sb_final_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
